// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
//   Shared definitions for the load/store unit:
//     - RV32I funct3 encodings for loads and stores (F3_*)
//     - FSM state type lsu_state_t (IDLE / ACCESS / RESP)
//     - f3_legal(): which funct3 values are legal for a load or a store
// -----------------------------------------------------------------------------
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } lsu_state_t;

   // Stores only have B/H/W; loads add the unsigned BU/HU variants.
   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      logic ok;
      if (we) begin
         ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      end else begin
         ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
              (f3 == F3_BU) || (f3 == F3_HU);
      end
      return ok;
   endfunction

endpackage

// File: rtl/lsu_if.sv
// -----------------------------------------------------------------------------
// lsu_req_if / lsu_mem_if
//   Bus bundles for the load/store unit.
//
//   Handshake rule for both bundles: a transfer happens in a cycle where the
//   master's valid and the slave's ready are both high at the rising clock
//   edge. The master holds valid and its payload stable until that edge.
//
//   lsu_req_if (core <-> lsu)
//     master (core): req_valid, req_we, req_funct3, req_addr, req_wdata out;
//                    req_ready, resp_valid, resp_rdata, resp_err in
//     slave  (lsu) : mirror image
//     resp_valid is a one-cycle completion pulse, resp_err/resp_rdata are
//     meaningful only while resp_valid is high.
//
//   lsu_mem_if (lsu <-> data memory)
//     master (lsu)   : mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb out;
//                      mem_ready, mem_rdata in
//     slave (memory) : mirror image
//     mem_rdata is sampled in the cycle where mem_valid && mem_ready.
// -----------------------------------------------------------------------------
interface lsu_req_if;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

interface lsu_mem_if;
   logic        mem_valid;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   modport master (
      output mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
//   Combinational data alignment for the load/store unit.
//     Store side: byte/halfword lane replication, byte strobes, misalign detect
//     Load side : lane select plus sign/zero extension
//
//   Ports
//     we_i        1 = store, 0 = load
//     funct3_i    RV32I funct3
//     off_i       byte offset addr[1:0]
//     wdata_i     raw store data (rs2)
//     rdata_i     raw memory read word
//     st_wdata_o  lane-replicated store data
//     st_wstrb_o  byte strobes (0 for loads)
//     misalign_o  misaligned H/W access (only when LSU_MISALIGN_TRAP_EN)
//     ld_data_o   extended load data
//
//   Configuration: LSU_MISALIGN_TRAP_EN enables misalign_o. Without it,
//   misaligned H/W accesses are silently pulled down to natural alignment.
// -----------------------------------------------------------------------------
module lsu_align
   import lsu_pkg::*;
(
   input  logic        we_i,
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] st_wdata_o,
   output logic [3:0]  st_wstrb_o,
   output logic        misalign_o,
   output logic [31:0] ld_data_o
);

   logic [1:0]  eff_off;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // funct3[1:0] encodes the access size for both signed and unsigned forms.
   always_comb begin
      misalign_o = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      if (funct3_i[1:0] == 2'b01) begin
         misalign_o = off_i[0];
      end else if (funct3_i[1:0] == 2'b10) begin
         misalign_o = (off_i != 2'b00);
      end
`endif
   end

   // Offset after forcing natural alignment; identical to off_i for every
   // access that is legal when misalignment traps.
   always_comb begin
      case (funct3_i[1:0])
         2'b00:   eff_off = off_i;
         2'b01:   eff_off = {off_i[1], 1'b0};
         default: eff_off = 2'b00;
      endcase
   end

   always_comb begin
      case (funct3_i)
         F3_B: begin
            st_wdata_o = {4{wdata_i[7:0]}};
            st_wstrb_o = 4'b0001 << eff_off;
         end
         F3_H: begin
            st_wdata_o = {2{wdata_i[15:0]}};
            st_wstrb_o = 4'b0011 << eff_off;
         end
         default: begin
            st_wdata_o = wdata_i;
            st_wstrb_o = 4'b1111;
         end
      endcase
      if (!we_i) begin
         st_wstrb_o = 4'b0000;
      end
   end

   always_comb begin
      case (off_i)
         2'd0:    ld_byte = rdata_i[7:0];
         2'd1:    ld_byte = rdata_i[15:8];
         2'd2:    ld_byte = rdata_i[23:16];
         default: ld_byte = rdata_i[31:24];
      endcase
      ld_half = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   end

   always_comb begin
      case (funct3_i)
         F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
         F3_BU:   ld_data_o = {24'h000000, ld_byte};
         F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
         F3_HU:   ld_data_o = {16'h0000, ld_half};
         default: ld_data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu
//   Load/store unit: turns one core request into one valid/ready transaction
//   on the data memory bus and returns a single-cycle response.
//
//   Parameters
//     TIMEOUT_CYCLES  cycles waited for mem_ready before an error (0 = never)
//
//   Ports
//     clk, rst_n   clock, asynchronous active-low reset
//     req          lsu_req_if.slave  - core request / response
//     mem          lsu_mem_if.master - data memory bus
//     state_o      current FSM state (debug)
//
//   Configuration: LSU_MISALIGN_TRAP_EN turns misaligned H/W accesses into
//   immediate errors instead of aligned-down accesses.
//
//   All outputs are registered; mem_ready/mem_rdata only reach flops.
// -----------------------------------------------------------------------------
module lsu
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   lsu_req_if.slave   req,
   lsu_mem_if.master  mem,
   output lsu_state_t state_o
);

   // Counter only ever holds values up to TIMEOUT_CYCLES before clearing.
   localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TMO_LIMIT = CW'(TIMEOUT_CYCLES);

   lsu_state_t    state_q;
   logic          we_q;
   logic [2:0]    f3_q;
   logic [1:0]    off_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   logic          req_ready_q;
   logic          resp_valid_q;
   logic          resp_err_q;
   logic [31:0]   resp_rdata_q;
   logic          mem_valid_q;
   logic          mem_we_q;
   logic [31:0]   mem_addr_q;
   logic [31:0]   mem_wdata_q;
   logic [3:0]    mem_wstrb_q;

   logic          is_idle;
   logic          al_we;
   logic [2:0]    al_f3;
   logic [1:0]    al_off;
   logic [31:0]   al_wdata;
   logic [3:0]    al_wstrb;
   logic          al_misalign;
   logic [31:0]   al_ld;
   logic          reject;
   logic          timeout_hit;

   // In IDLE the aligner looks at the incoming request (store side and
   // misalign check); afterwards it looks at the captured request so the
   // load side can extend mem_rdata.
   assign is_idle = (state_q == ST_IDLE);
   assign al_we   = is_idle ? req.req_we         : we_q;
   assign al_f3   = is_idle ? req.req_funct3     : f3_q;
   assign al_off  = is_idle ? req.req_addr[1:0]  : off_q;

   lsu_align u_align (
      .we_i       (al_we),
      .funct3_i   (al_f3),
      .off_i      (al_off),
      .wdata_i    (req.req_wdata),
      .rdata_i    (mem.mem_rdata),
      .st_wdata_o (al_wdata),
      .st_wstrb_o (al_wstrb),
      .misalign_o (al_misalign),
      .ld_data_o  (al_ld)
   );

   assign reject      = !f3_legal(req.req_we, req.req_funct3) || al_misalign;
   assign cnt_d       = cnt_q + CW'(1);
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_d == TMO_LIMIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         we_q         <= 1'b0;
         f3_q         <= 3'b000;
         off_q        <= 2'b00;
         cnt_q        <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'h0;
         mem_valid_q  <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 32'h0;
         mem_wdata_q  <= 32'h0;
         mem_wstrb_q  <= 4'h0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req.req_valid) begin
                  we_q        <= req.req_we;
                  f3_q        <= req.req_funct3;
                  off_q       <= req.req_addr[1:0];
                  req_ready_q <= 1'b0;
                  if (reject) begin
                     // Illegal or trapped access: answer without touching memory.
                     state_q      <= ST_RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_rdata_q <= 32'h0;
                  end else begin
                     state_q     <= ST_ACCESS;
                     mem_valid_q <= 1'b1;
                     mem_we_q    <= req.req_we;
                     mem_addr_q  <= {req.req_addr[31:2], 2'b00};
                     mem_wdata_q <= al_wdata;
                     mem_wstrb_q <= al_wstrb;
                  end
               end
            end

            ST_ACCESS: begin
               // mem_ready wins over a timeout landing in the same cycle.
               if (mem.mem_ready) begin
                  state_q      <= ST_RESP;
                  mem_valid_q  <= 1'b0;
                  cnt_q        <= '0;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b0;
                  resp_rdata_q <= we_q ? 32'h0 : al_ld;
               end else if (timeout_hit) begin
                  state_q      <= ST_RESP;
                  mem_valid_q  <= 1'b0;
                  cnt_q        <= '0;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b1;
                  resp_rdata_q <= 32'h0;
               end else begin
                  cnt_q <= cnt_d;
               end
            end

            ST_RESP: begin
               state_q      <= ST_IDLE;
               resp_valid_q <= 1'b0;
               resp_err_q   <= 1'b0;
               req_ready_q  <= 1'b1;
            end

            default: begin
               state_q      <= ST_IDLE;
               cnt_q        <= '0;
               mem_valid_q  <= 1'b0;
               resp_valid_q <= 1'b0;
               resp_err_q   <= 1'b0;
               req_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign req.req_ready  = req_ready_q;
   assign req.resp_valid = resp_valid_q;
   assign req.resp_err   = resp_err_q;
   assign req.resp_rdata = resp_rdata_q;

   assign mem.mem_valid  = mem_valid_q;
   assign mem.mem_we     = mem_we_q;
   assign mem.mem_addr   = mem_addr_q;
   assign mem.mem_wdata  = mem_wdata_q;
   assign mem.mem_wstrb  = mem_wstrb_q;

   assign state_o        = state_q;

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the single-cycle core, directly downstream of the ALU. It takes the ALU result as the effective address and rs2 as store data, and runs one valid/ready transaction per request against the data memory. It returns sign- or zero-extended load data, and holds the core through a single request handshake until the access completes.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles spent waiting on `mem_ready` before an error; 0 disables the timeout.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  1  core presents a memory operation.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3: loads `000` LB, `001` LH, `010` LW, `100` LBU, `101` LHU; stores `000` SB, `001` SH, `010` SW.
- `req_addr`  in  32  effective address (ALU result).
- `req_wdata`  in  32  store data (rs2).
- `req_ready`  out  1  LSU idle and able to accept a request.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  qualified by `resp_valid`; set for illegal funct3, misalignment (macro on) or timeout.
- `mem_valid`  out  1  memory request.
- `mem_ready`  in  1  memory accepts or completes the request.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  32  word address; bits [1:0] are always 0.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_wstrb`  out  4  byte strobes; 0 for loads.
- `mem_rdata`  in  32  read data, sampled in the cycle where `mem_valid && mem_ready`.

## Operation
- Reset values: state IDLE; `req_ready` 1; `mem_valid` 0; `resp_valid` 0; `resp_err` 0; all data, address and strobe outputs 0; timeout counter 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`: register `we`, `funct3`, `addr` and `wdata`.
  - Illegal funct3 (load `011/110/111`, store `011` and above) → RESP with error, no memory access.
  - Otherwise → ACCESS.
- ACCESS:
  - `mem_valid`=1. `mem_addr`, `mem_we`, `mem_wdata` and `mem_wstrb` come from registers and stay stable.
  - On `mem_ready`: capture the extended read data → RESP.
  - Counter increments every cycle without `mem_ready`. If the counter reaches `TIMEOUT_CYCLES` (nonzero) → RESP with error, `mem_valid` dropped.
  - `mem_ready` in the same cycle as the limit: the access completes successfully.
- RESP: `resp_valid`=1 for exactly one cycle → IDLE. The counter clears on leaving ACCESS.
- Byte offset `off` = `addr[1:0]`.
- Stores:
  - SB: `wdata` = `{4{b}}`, `wstrb` = `0001<<off`.
  - SH: `wdata` = `{2{h}}`, `wstrb` = `0011<<off`.
  - SW: `wstrb` = `1111`.
- Loads:
  - LB/LBU: lane `rdata[8*off+:8]`.
  - LH/LHU: `rdata[16*off[1]+:16]`.
  - Sign extension for LB/LH; zero extension for LBU/LHU.
- `req_valid` outside IDLE is ignored; the core must hold the request until `req_ready`.
- Asynchronous reset mid-access abandons the transaction: `mem_valid` falls immediately and no response is produced.

## Timing
- Request accepted in cycle T.
- `mem_valid` high from T+1.
- With `mem_ready` in cycle T+k (k≥1), `resp_valid` is high at T+k+1.
- Minimum latency is 2 cycles from acceptance to response.
- Errors without a memory access respond at T+1.
- `req_ready` is low from T+1 until the cycle after `resp_valid`; back-to-back requests can be accepted every 3 cycles at best.
- No combinational path from `mem_ready` or `mem_rdata` to any output.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: LH/LHU/SH with `off[0]`=1, or LW/SW with `off`≠0, go IDLE→RESP with `resp_err`=1 and no memory access.
- Undefined: misaligned halfword and word accesses are issued with the address forced down to natural alignment. LH uses `off[1]`; LW/SW use a word lane with `wstrb` `1111`. No error is raised.

## Structure
- `lsu_pkg` contains:
  - funct3 localparams `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - The state enum `lsu_state_t`.
- Sub-module `lsu_align` (combinational):
  - Store side: store lane replication, strobe generation and misalignment detect.
  - Load side: load lane select and extension.
- The top holds the FSM, request registers and timeout counter.

## Test plan
- SB at addr `0x1003`, wdata `0x000000AB`, `mem_ready` tied 1 → `mem_addr` `0x1000`, `mem_wstrb` `1000`, `mem_wdata` `0xABABABAB`, `resp_valid` at T+2, `resp_err` 0.
- LB vs LBU at `0x2001` with `mem_rdata` `0x0000F000` → `resp_rdata` `0xFFFFFFF0` vs `0x000000F0`. LH at `0x2002` with `mem_rdata` `0x80010000` → `0xFFFF8001`.
- LW with `mem_ready` delayed 5 cycles → `mem_valid` held, address stable, `resp_valid` at T+7, `req_ready` low throughout.
- `mem_ready` never asserted, `TIMEOUT_CYCLES`=4 → `mem_valid` drops, `resp_valid` with `resp_err`=1 and `resp_rdata` 0.
- LW at `0x3002`: macro on → error at T+1 and `mem_valid` never high. Macro off → `mem_addr` `0x3000`, no error.
- `rst_n` pulsed low during ACCESS → `mem_valid` 0 asynchronously, no `resp_valid`, `req_ready` 1 after release; funct3 `011` load → immediate error.
